exec_time_uart_report: RTL and testbench

Downstream reporter for the microSD read benchmark tasks. When the selected task raises its end flag, this block captures that task's 64-bit `exec_time` cycle count and a task tag. It then transmits them as an ASCII line over a UART TX pin (8N1), so a host terminal can log raw, encrypted and compare runs without the 7-segment display. It sits after the `exec_time` mux and the task end flags in the top level, and drives only the board UART TX pad.

---
 rtl/eluks_report_pkg.sv | 50 +++++
 rtl/uart_tx_byte.sv | 80 ++++++++
 rtl/exec_time_uart_report.sv | 142 ++++++++++++++
 tb/tb_exec_time_uart_report.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eluks_report_pkg.sv
// Shared definitions for the exec_time UART reporter: ASCII constants,
// character helpers and the formatter / serializer state encodings.
// Optional feature macro: ELUKS_REPORT_CRLF_EN (adds CR LF line ending).
package eluks_report_pkg;

  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_E     = 8'h45;
  localparam logic [7:0] ASCII_C     = 8'h43;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  typedef enum logic [2:0] {
    F_IDLE,
    F_PREFIX,
    F_COLON,
    F_HEX,
`ifdef ELUKS_REPORT_CRLF_EN
    F_CR,
    F_LF,
`endif
    F_FINISH
  } fmt_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } ser_state_t;

  // Uppercase hex digit for one nibble
  function automatic logic [7:0] nib_to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Line prefix character selected by the task tag
  function automatic logic [7:0] tag_to_prefix(input logic [1:0] t);
    logic [7:0] c;
    case (t)
      2'd0:    c = ASCII_R;
      2'd1:    c = ASCII_E;
      2'd2:    c = ASCII_C;
      default: c = ASCII_QMARK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with baud counter. A new byte may be accepted in
// the last cycle of a stop bit so characters run back-to-back.
module uart_tx_byte
  import eluks_report_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       tx,
  output logic       byte_ready,
  output logic       byte_done
);

  localparam int unsigned DIV   = CLK_HZ / BAUD;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  ser_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_tx;

  logic w_bit_end;
  logic w_accept;

  assign w_bit_end  = (r_cnt == CNT_W'(DIV - 1));
  assign byte_done  = (r_state == S_STOP) && w_bit_end;
  assign byte_ready = (r_state == S_IDLE) || byte_done;
  assign w_accept   = byte_valid && byte_ready;
  assign tx         = r_tx;

  // Serializer FSM: start bit, 8 data bits LSB first, stop bit, each DIV cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else if (w_accept) begin
      r_state <= S_START;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= byte_data;
      r_tx    <= 1'b0;
    end else if (r_state != S_IDLE) begin
      if (!w_bit_end) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
        case (r_state)
          S_START: begin
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end
          S_DATA: begin
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_tx    <= r_shift[1];
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end
          S_STOP: begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/exec_time_uart_report.sv
// Captures a task's 64-bit exec_time and tag on the rising edge of its end
// flag and sends "<P>:<16 hex digits>" over UART 8N1.
// Optional feature macro: ELUKS_REPORT_CRLF_EN (appends CR LF to each line).
module exec_time_uart_report
  import eluks_report_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        end_signal,
  input  logic [63:0] exec_time,
  input  logic [1:0]  tag,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  fmt_state_t  r_fstate;
  logic        r_end_prev;
  logic [63:0] r_time;
  logic [1:0]  r_tag;
  logic [3:0]  r_idx;
  logic        r_busy;
  logic        r_done;

  logic        w_byte_valid;
  logic [7:0]  w_byte_data;
  logic        w_byte_ready;
  logic        w_byte_done;
  logic        w_accept;
  logic        w_trigger;

  assign w_trigger = end_signal && !r_end_prev && !r_busy;
  assign w_accept  = w_byte_valid && w_byte_ready;
  assign busy      = r_busy;
  assign done      = r_done;

  // Character offered to the serializer in each formatter state
  always_comb begin
    w_byte_valid = 1'b0;
    w_byte_data  = 8'h00;
    case (r_fstate)
      F_PREFIX: begin
        w_byte_valid = 1'b1;
        w_byte_data  = tag_to_prefix(r_tag);
      end
      F_COLON: begin
        w_byte_valid = 1'b1;
        w_byte_data  = ASCII_COLON;
      end
      F_HEX: begin
        w_byte_valid = 1'b1;
        w_byte_data  = nib_to_ascii(r_time[63:60]);
      end
`ifdef ELUKS_REPORT_CRLF_EN
      F_CR: begin
        w_byte_valid = 1'b1;
        w_byte_data  = ASCII_CR;
      end
      F_LF: begin
        w_byte_valid = 1'b1;
        w_byte_data  = ASCII_LF;
      end
`endif
      default: ;
    endcase
  end

  // Formatter FSM: capture on trigger, step one character per serializer hand-off
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fstate   <= F_IDLE;
      r_end_prev <= 1'b0;
      r_time     <= '0;
      r_tag      <= '0;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_end_prev <= end_signal;
      r_done     <= 1'b0;
      case (r_fstate)
        F_IDLE: begin
          if (w_trigger) begin
            r_time   <= exec_time;
            r_tag    <= tag;
            r_busy   <= 1'b1;
            r_fstate <= F_PREFIX;
          end
        end
        F_PREFIX: if (w_accept) r_fstate <= F_COLON;
        F_COLON: begin
          if (w_accept) begin
            r_idx    <= '0;
            r_fstate <= F_HEX;
          end
        end
        F_HEX: begin
          if (w_accept) begin
            r_time <= {r_time[59:0], 4'h0};
            r_idx  <= r_idx + 4'd1;
            if (r_idx == 4'd15) begin
`ifdef ELUKS_REPORT_CRLF_EN
              r_fstate <= F_CR;
`else
              r_fstate <= F_FINISH;
`endif
            end
          end
        end
`ifdef ELUKS_REPORT_CRLF_EN
        F_CR: if (w_accept) r_fstate <= F_LF;
        F_LF: if (w_accept) r_fstate <= F_FINISH;
`endif
        F_FINISH: begin
          if (w_byte_done) begin
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_fstate <= F_IDLE;
          end
        end
        default: r_fstate <= F_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_uart_tx_byte (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (w_byte_valid),
    .byte_data  (w_byte_data),
    .tx         (tx),
    .byte_ready (w_byte_ready),
    .byte_done  (w_byte_done)
  );

endmodule

// File: tb/tb_exec_time_uart_report.sv
// Scoreboard bench for exec_time_uart_report: stimulus pushes the expected
// line and timing; a UART decoder and a done monitor check them.
module tb_exec_time_uart_report;

  localparam int unsigned CLK_HZ = 1000000;
  localparam int unsigned BAUD   = 100000;
  localparam int DIV = CLK_HZ / BAUD;
`ifdef ELUKS_REPORT_CRLF_EN
  localparam int LINE_CHARS = 20;
`else
  localparam int LINE_CHARS = 18;
`endif
  localparam int LINE_CYC = LINE_CHARS * 10 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        end_signal = 1'b0;
  logic [63:0] exec_time = '0;
  logic [1:0]  tag = '0;
  logic        tx;
  logic        busy;
  logic        done;

  exec_time_uart_report #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk        (clk),
    .rst        (rst),
    .end_signal (end_signal),
    .exec_time  (exec_time),
    .tag        (tag),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int resync = 0;
  int line_start = 0;
  string rx_all = "";
  int char_fall[int];
  string exp_line[$];
  int exp_fall[$];
  int exp_done[$];

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic string printable(input string s);
    string r;
    r = s;
    for (int i = 0; i < r.len(); i++)
      if (r.getc(i) < 8'h20) r.putc(i, 8'h2E);
    return r;
  endfunction

  // Expected report text straight from the line format rules
  function automatic string make_line(input logic [1:0] tg, input logic [63:0] t);
    string pre;
    string hex;
    case (tg)
      2'd0:    pre = "R";
      2'd1:    pre = "E";
      2'd2:    pre = "C";
      default: pre = "?";
    endcase
    hex = $sformatf("%016h", t);
    hex = hex.toupper();
`ifdef ELUKS_REPORT_CRLF_EN
    return {pre, ":", hex, "\015\012"};
`else
    return {pre, ":", hex};
`endif
  endfunction

  // UART receiver: samples mid-bit, records the cycle each start bit was seen
  initial begin : decoder
    logic [7:0] ch;
    int f;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        f = cyc;
        repeat (DIV / 2 - 1) @(negedge clk);
        if (tx === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            ch[i] = tx;
          end
          repeat (DIV) @(negedge clk);
          char_fall[rx_all.len()] = f;
          rx_all = $sformatf("%s%c", rx_all, ch);
        end
      end
    end
  end

  // Done monitor: pops the scoreboard on every done pulse
  initial begin : monitor
    int seen_resync;
    string got;
    string want;
    int f;
    seen_resync = 0;
    forever begin
      @(negedge clk);
      if (resync != seen_resync) begin
        seen_resync = resync;
        line_start = rx_all.len();
      end
      if (rst === 1'b0 && done === 1'b1) begin
        got = rx_all.substr(line_start, rx_all.len() - 1);
        f = char_fall.exists(line_start) ? char_fall[line_start] : -1;
        line_start = rx_all.len();
        if (exp_line.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done pulse at cycle %0d, required none", cyc);
        end else begin
          want = exp_line.pop_front();
          total++;
          if (got != want) begin
            bad++;
            $display("FAIL line_text: got \"%s\" required \"%s\"", printable(got), printable(want));
          end
          chk("tx_fall_cycle", f, exp_fall.pop_front());
          chk("done_cycle", cyc, exp_done.pop_front());
        end
      end
    end
  end

  task automatic push_exp(input logic [1:0] tg, input logic [63:0] t, input int trig);
    exp_line.push_back(make_line(tg, t));
    exp_fall.push_back(trig + 1);
    exp_done.push_back(trig + 1 + LINE_CYC);
  endtask

  // Wait for busy to drop; optional junk on inputs and end_signal while busy
  task automatic wait_line_end(input int trig, input bit junk, input bit keep_end);
    int n;
    n = 0;
    while (busy === 1'b1 && n < LINE_CYC + 100) begin
      if (junk) begin
        exec_time = {$urandom, $urandom};
        tag = 2'($urandom);
        if (!keep_end && $urandom_range(0, 15) == 0) end_signal = ~end_signal;
      end
      @(negedge clk);
      n++;
    end
    chk("busy_fall_cycle", cyc, trig + 1 + LINE_CYC);
    chk("tx_idle_after_line", tx, 1);
  endtask

  task automatic send_line(input logic [1:0] tg, input logic [63:0] t, input bit junk);
    int trig;
    @(negedge clk);
    end_signal = 1'b0;
    tag = tg;
    exec_time = t;
    @(negedge clk);
    end_signal = 1'b1;
    trig = cyc + 1;
    push_exp(tg, t, trig);
    @(negedge clk);
    chk("busy_after_trigger", busy, 1);
    wait_line_end(trig, junk, 1'b0);
  endtask

  initial begin : stimulus
    int trig;
    logic [63:0] t;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_tx", tx, 1);
    resync++;

    send_line(2'd0, 64'h0000_0000_0001_ABCD, 1'b0);
    send_line(2'd1, 64'hFEDC_BA98_7654_3210, 1'b0);
    send_line(2'd3, {$urandom, $urandom}, 1'b0);
    send_line(2'd2, {$urandom, $urandom}, 1'b0);
    for (int i = 0; i < 5; i++) send_line(2'($urandom), {$urandom, $urandom}, 1'b1);

    // Abort inside the 5th character's data bits; no line expected
    @(negedge clk);
    end_signal = 1'b0;
    tag = 2'd2;
    exec_time = {$urandom, $urandom};
    @(negedge clk);
    end_signal = 1'b1;
    trig = cyc + 1;
    while (cyc < trig + 1 + 4 * 10 * DIV + 4 * DIV) @(negedge clk);
    chk("busy_before_abort", busy, 1);
    rst = 1'b1;
    end_signal = 1'b0;
    @(negedge clk);
    chk("tx_after_abort", tx, 1);
    chk("busy_after_abort", busy, 0);
    chk("done_after_abort", done, 0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    resync++;
    chk("busy_idle_after_abort", busy, 0);

    send_line(2'($urandom), {$urandom, $urandom}, 1'b1);

    // end_signal held high across reset release: one line only
    @(negedge clk);
    rst = 1'b1;
    end_signal = 1'b1;
    tag = 2'd1;
    t = {$urandom, $urandom};
    exec_time = t;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    trig = cyc + 1;
    push_exp(2'd1, t, trig);
    @(negedge clk);
    chk("busy_after_level_trigger", busy, 1);
    wait_line_end(trig, 1'b1, 1'b1);
    repeat (LINE_CYC + 200) @(negedge clk);
    chk("no_retrigger_busy", busy, 0);

    repeat (20) @(negedge clk);
    chk("pending_lines", exp_line.size(), 0);
    chk("stray_chars", rx_all.len() - line_start, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
